// File: rtl/score_scan_ctrl.sv
// ---------------------------------------------------------------------------
// score_scan_ctrl
//   Time-multiplexes a two-digit BCD score onto a shared 4-bit digit bus.
//   The scan order is ONES -> GAP1 -> TENS -> GAP2. GAP1 and GAP2 are blank
//   slots that stop one digit ghosting into the next. When BLANK_CYCLES==0
//   there are no gaps and the order is ONES -> TENS.
//   A loaded score is staged and only reaches the display registers at a
//   frame boundary, so a frame never shows half an update. The block also
//   does leading-zero suppression and whole-display flashing.
//
// Parameters
//   DWELL_W       width of dwell and of the dwell/gap counter
//   BLANK_CYCLES  number of blank cycles after each digit (0 = no gaps)
//   FLASH_FRAMES  number of frames per flash half-period (>= 1)
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   dwell       each digit is shown for dwell+1 cycles; sampled live
//   bcd_ones    ones digit of the incoming score
//   bcd_tens    tens digit of the incoming score
//   load        one-cycle strobe that captures bcd_ones/bcd_tens
//   lz_blank    blank the tens digit when the displayed tens value is 0
//   flash_en    flash the display every FLASH_FRAMES frames
//   digit_out   BCD value for the selected digit; 0 while digit_sel==00
//   digit_sel   one-hot digit enable: 01 = ones, 10 = tens, 00 = blank
//   frame_done  one-cycle pulse on the last cycle of each frame
// ---------------------------------------------------------------------------
module score_scan_ctrl #(
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = 2,
    parameter int FLASH_FRAMES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [3:0]         bcd_ones,
    input  logic [3:0]         bcd_tens,
    input  logic               load,
    input  logic               lz_blank,
    input  logic               flash_en,
    output logic [3:0]         digit_out,
    output logic [1:0]         digit_sel,
    output logic               frame_done
);

    localparam logic [1:0] S_ONES = 2'd0;
    localparam logic [1:0] S_GAP1 = 2'd1;
    localparam logic [1:0] S_TENS = 2'd2;
    localparam logic [1:0] S_GAP2 = 2'd3;

    // The frame closes in GAP2, or in TENS when there are no gaps.
    localparam logic [1:0] S_LAST = (BLANK_CYCLES == 0) ? S_TENS : S_GAP2;

    // Gap states run for cnt = 0 .. BLANK_CYCLES-1.
    localparam logic [DWELL_W-1:0] GAP_LAST =
        DWELL_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    localparam int FCNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FLASH_FRAMES - 1);

    logic [1:0]         state, next_state;
    logic [DWELL_W-1:0] cnt;
    logic               state_last;

    logic [3:0]         stage_ones, stage_tens;
    logic               pending;
    logic [3:0]         disp_ones, disp_tens;

    logic               flash_phase;
    logic [FCNT_W-1:0]  fcnt;

    // Sequencing. A digit state ends on any cycle where cnt >= dwell.
    // Because dwell is sampled live, lowering it below cnt ends the digit
    // at the next edge.
    always_comb begin
        state_last = 1'b0;
        next_state = state;
        case (state)
            S_ONES: begin
                state_last = (cnt >= dwell);
                next_state = (BLANK_CYCLES == 0) ? S_TENS : S_GAP1;
            end
            S_GAP1: begin
                state_last = (cnt == GAP_LAST);
                next_state = S_TENS;
            end
            S_TENS: begin
                state_last = (cnt >= dwell);
                next_state = (BLANK_CYCLES == 0) ? S_ONES : S_GAP2;
            end
            default: begin
                state_last = (cnt == GAP_LAST);
                next_state = S_ONES;
            end
        endcase
    end

    // frame_done has to line up with the real last cycle of the frame.
    // When there are no gaps, the frame ends in TENS, and that cycle depends
    // on the live dwell value.
    assign frame_done = state_last && (state == S_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_ONES;
            cnt         <= '0;
            stage_ones  <= 4'd0;
            stage_tens  <= 4'd0;
            pending     <= 1'b0;
            disp_ones   <= 4'd0;
            disp_tens   <= 4'd0;
            flash_phase <= 1'b0;
            fcnt        <= '0;
        end else begin
            if (state_last) begin
                state <= next_state;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // Staging always holds the newest load. At a frame boundary the
            // display takes the newest value. A load on that same cycle
            // bypasses staging, because staging only updates at the edge.
            if (load) begin
                stage_ones <= bcd_ones;
                stage_tens <= bcd_tens;
            end
            if (frame_done) begin
                if (load) begin
                    disp_ones <= bcd_ones;
                    disp_tens <= bcd_tens;
                end else if (pending) begin
                    disp_ones <= stage_ones;
                    disp_tens <= stage_tens;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end

            if (!flash_en) begin
                flash_phase <= 1'b0;
                fcnt        <= '0;
            end else if (frame_done) begin
                if (fcnt == FCNT_LAST) begin
                    flash_phase <= ~flash_phase;
                    fcnt        <= '0;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

    // Outputs are decoded from the registered state. Suppression and
    // flashing only blank the bus; the scan timing does not change.
    always_comb begin
        digit_sel = 2'b00;
        digit_out = 4'd0;
        if (!flash_phase) begin
            case (state)
                S_ONES: begin
                    digit_sel = 2'b01;
                    digit_out = disp_ones;
                end
                S_TENS: begin
                    if (!(lz_blank && disp_tens == 4'd0)) begin
                        digit_sel = 2'b10;
                        digit_out = disp_tens;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
